// File: rtl/tl_memory_model.sv
// -----------------------------------------------------------------------------
// tl_memory_model
//   Word-organised backing store behind the TileLink L2 slave adapter.
//   Single-cycle read and write command pulses are accepted on every clock edge.
//   Each one is answered by a single-cycle completion pulse one cycle later.
//   Registered monitor outputs mirror every performed access so that
//   scoreboards and trace loggers can follow the traffic.
//
// Handshake semantics:
//   write_valid / read_valid are command pulses that are always accepted
//   (there is no backpressure).
//   write_ready / read_data_valid are registered completion pulses. Each is
//   high for exactly the one cycle after the accepting edge.
//   read_data and the mem_*_addr/data/mask monitor outputs hold their last
//   values between commands.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (clears storage and outputs)
//   write_valid      write command pulse
//   write_addr       byte address of write
//   write_data       write data
//   write_mask       byte enables, bit i -> data[8i+7:8i]
//   write_ready      write-complete pulse
//   read_valid       read command pulse
//   read_addr        byte address of read
//   read_data        read result, held until the next read completes
//   read_data_valid  read-complete pulse
//   mem_write_*      monitor copy of the last performed write
//   mem_read_*       monitor copy of the last performed read
// -----------------------------------------------------------------------------
module tl_memory_model #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BYTES  = 8,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_valid,
  input  logic [ADDR_BITS-1:0]    write_addr,
  input  logic [DATA_BYTES*8-1:0] write_data,
  input  logic [DATA_BYTES-1:0]   write_mask,
  output logic                    write_ready,
  input  logic                    read_valid,
  input  logic [ADDR_BITS-1:0]    read_addr,
  output logic [DATA_BYTES*8-1:0] read_data,
  output logic                    read_data_valid,
  output logic                    mem_write_valid,
  output logic [ADDR_BITS-1:0]    mem_write_addr,
  output logic [DATA_BYTES*8-1:0] mem_write_data,
  output logic [DATA_BYTES-1:0]   mem_write_mask,
  output logic                    mem_read_valid,
  output logic [ADDR_BITS-1:0]    mem_read_addr,
  output logic [DATA_BYTES*8-1:0] mem_read_data
);

  localparam int OFF_BITS  = $clog2(DATA_BYTES);
  localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
  localparam int DATA_BITS = DATA_BYTES * 8;

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

  // Offset bits below the index and all bits above it are dropped.
  // Addresses therefore alias modulo DEPTH_WORDS*DATA_BYTES.
  logic [IDX_BITS-1:0]  w_idx;
  logic [IDX_BITS-1:0]  r_idx;
  logic [DATA_BITS-1:0] w_merged;

  assign w_idx = write_addr[OFF_BITS +: IDX_BITS];
  assign r_idx = read_addr[OFF_BITS +: IDX_BITS];

  // Byte-masked merge of the write data into the currently stored word.
  always_comb begin
    w_merged = mem[w_idx];
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (write_mask[i]) begin
        w_merged[8*i +: 8] = write_data[8*i +: 8];
      end
    end
  end

  // Reads sample mem[] before this edge's write lands (non-blocking update).
  // This gives read-before-write ordering for a same-index write in the
  // same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
      write_ready     <= 1'b0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_write_addr  <= '0;
      mem_write_data  <= '0;
      mem_write_mask  <= '0;
      mem_read_valid  <= 1'b0;
      mem_read_addr   <= '0;
      mem_read_data   <= '0;
    end else begin
      write_ready     <= write_valid;
      mem_write_valid <= write_valid;
      read_data_valid <= read_valid;
      mem_read_valid  <= read_valid;
      if (write_valid) begin
        mem[w_idx]     <= w_merged;
        mem_write_addr <= write_addr;
        mem_write_data <= write_data;
        mem_write_mask <= write_mask;
      end
      if (read_valid) begin
        read_data     <= mem[r_idx];
        mem_read_addr <= read_addr;
        mem_read_data <= mem[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_tl_memory_model.sv
// -----------------------------------------------------------------------------
// tb_tl_memory_model
//   Directed and randomised checks of tl_memory_model against a word-array
//   model. Expected read data is queued when a read is driven. It is popped
//   when the completion cycle is sampled.
// -----------------------------------------------------------------------------
module tb_tl_memory_model;

  logic        clk;
  logic        rst;
  logic        write_valid;
  logic [31:0] write_addr;
  logic [63:0] write_data;
  logic [7:0]  write_mask;
  logic        write_ready;
  logic        read_valid;
  logic [31:0] read_addr;
  logic [63:0] read_data;
  logic        read_data_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_addr;
  logic [63:0] mem_write_data;
  logic [7:0]  mem_write_mask;
  logic        mem_read_valid;
  logic [31:0] mem_read_addr;
  logic [63:0] mem_read_data;

  tl_memory_model #(
    .ADDR_BITS(32),
    .DATA_BYTES(8),
    .DEPTH_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_valid(write_valid),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_mask(write_mask),
    .write_ready(write_ready),
    .read_valid(read_valid),
    .read_addr(read_addr),
    .read_data(read_data),
    .read_data_valid(read_data_valid),
    .mem_write_valid(mem_write_valid),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask),
    .mem_read_valid(mem_read_valid),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] model [256];
  logic [63:0] exp_q[$];
  int          n_cmp;
  int          n_fail;

  logic        pend_wr;
  logic        pend_rd;
  logic [31:0] pend_waddr;
  logic [63:0] pend_wdata;
  logic [7:0]  pend_wmask;
  logic [31:0] pend_raddr;

  logic [31:0] last_waddr;
  logic [63:0] last_wdata;
  logic [7:0]  last_wmask;
  logic [31:0] last_raddr;
  logic [63:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_tracking();
    for (int i = 0; i < 256; i++) model[i] = 64'd0;
    exp_q.delete();
    pend_wr    = 1'b0;
    pend_rd    = 1'b0;
    pend_waddr = '0;
    pend_wdata = '0;
    pend_wmask = '0;
    pend_raddr = '0;
    last_waddr = '0;
    last_wdata = '0;
    last_wmask = '0;
    last_raddr = '0;
    last_rdata = '0;
  endtask

  // Checks the outputs produced by the previous command (sampled at negedge).
  task automatic check_outputs();
    logic [63:0] e;
    chk("write_ready", write_ready, pend_wr);
    chk("mem_write_valid", mem_write_valid, pend_wr);
    if (pend_wr) begin
      last_waddr = pend_waddr;
      last_wdata = pend_wdata;
      last_wmask = pend_wmask;
    end
    chk("mem_write_addr", mem_write_addr, last_waddr);
    chk("mem_write_data", mem_write_data, last_wdata);
    chk("mem_write_mask", mem_write_mask, last_wmask);
    chk("read_data_valid", read_data_valid, pend_rd);
    chk("mem_read_valid", mem_read_valid, pend_rd);
    if (pend_rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL exp_q_underflow: observed empty queue expected an entry");
      end else begin
        e = exp_q.pop_front();
        last_rdata = e;
        last_raddr = pend_raddr;
      end
    end
    chk("read_data", read_data, last_rdata);
    chk("mem_read_data", mem_read_data, last_rdata);
    chk("mem_read_addr", mem_read_addr, last_raddr);
  endtask

  // One cycle of stimulus: check the previous cycle's completion, then drive.
  task automatic drive(input logic we, input logic [31:0] wa, input logic [63:0] wd,
                       input logic [7:0] wm, input logic re, input logic [31:0] ra);
    @(negedge clk);
    check_outputs();
    write_valid = we;
    write_addr  = wa;
    write_data  = wd;
    write_mask  = wm;
    read_valid  = re;
    read_addr   = ra;
    if (re) exp_q.push_back(model[ra[10:3]]);
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wm[i]) model[wa[10:3]][8*i +: 8] = wd[8*i +: 8];
      end
    end
    pend_wr    = we;
    pend_rd    = re;
    pend_waddr = wa;
    pend_wdata = wd;
    pend_wmask = wm;
    pend_raddr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 32'h0);
  endtask

  // Reset asserted together with write and read commands: nothing may complete.
  task automatic reset_with_cmd(input logic [31:0] wa, input logic [63:0] wd);
    @(negedge clk);
    check_outputs();
    rst         = 1'b1;
    write_valid = 1'b1;
    write_addr  = wa;
    write_data  = wd;
    write_mask  = 8'hFF;
    read_valid  = 1'b1;
    read_addr   = wa;
    @(negedge clk);
    chk("rst_write_ready", write_ready, 1'b0);
    chk("rst_read_data_valid", read_data_valid, 1'b0);
    chk("rst_mem_write_valid", mem_write_valid, 1'b0);
    chk("rst_mem_read_valid", mem_read_valid, 1'b0);
    chk("rst_read_data", read_data, 64'd0);
    chk("rst_mem_write_data", mem_write_data, 64'd0);
    chk("rst_mem_read_addr", mem_read_addr, 32'd0);
    rst         = 1'b0;
    write_valid = 1'b0;
    read_valid  = 1'b0;
    clear_tracking();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    write_valid = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    write_mask  = '0;
    read_valid  = 1'b0;
    read_addr   = '0;
    clear_tracking();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_write_ready", write_ready, 1'b0);
    chk("reset_read_data_valid", read_data_valid, 1'b0);
    chk("reset_read_data", read_data, 64'd0);
    chk("reset_mem_write_addr", mem_write_addr, 32'd0);
    chk("reset_mem_read_data", mem_read_data, 64'd0);
    rst = 1'b0;

    // Read of a cleared word.
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h0);
    idle();

    // Full write then read back.
    drive(1'b1, 32'h40, 64'h0011223344556677, 8'hFF, 1'b0, 32'h0);
    idle();
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h40);
    idle();

    // Partial write (low four bytes).
    drive(1'b1, 32'h40, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h40);
    idle();

    // Alias: 0x800 wraps onto word 0.
    drive(1'b1, 32'h800, 64'h00000000000000A5, 8'h01, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h000);
    idle();

    // Same-cycle write and read of one index: read returns the old value.
    drive(1'b1, 32'h40, 64'h7, 8'hFF, 1'b0, 32'h0);
    drive(1'b1, 32'h40, 64'h1, 8'hFF, 1'b1, 32'h40);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h40);
    idle();

    // All-zero mask still completes but leaves the word untouched.
    drive(1'b1, 32'h47, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h40);
    idle();

    // Randomised back-to-back traffic over a few indices with aliasing.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] wa;
      logic [31:0] ra;
      wa = (32'($urandom_range(0, 7)) << 3) | (32'($urandom_range(0, 3)) << 11)
           | 32'($urandom_range(0, 7));
      ra = (32'($urandom_range(0, 7)) << 3) | (32'($urandom_range(0, 3)) << 11)
           | 32'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), wa, {$urandom(), $urandom()},
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ra);
    end
    idle();

    // Reset with a write in flight, then every word must read zero.
    drive(1'b1, 32'h80, 64'h1234567812345678, 8'hFF, 1'b0, 32'h0);
    reset_with_cmd(32'h40, 64'hCAFEF00DCAFEF00D);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'(i * 8));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
